// File: rtl/uart_pkg.sv
// uart_pkg: shared UART states, character-size encoding and line levels
package uart_pkg;
  typedef enum logic [2:0] {IDLE, WAKE, START, DATA, PARITY, STOP1, STOP2} uart_state_e;
  localparam logic [1:0] DS_5 = 2'd0;
  localparam logic [1:0] DS_6 = 2'd1;
  localparam logic [1:0] DS_7 = 2'd2;
  localparam logic [1:0] DS_8 = 2'd3;
  localparam logic TX_IDLE = 1'b1;
  function automatic logic [3:0] size_bits(input logic [1:0] ds);
    return 4'd5 + {2'b00, ds - DS_5};
  endfunction
endpackage

// File: rtl/uart_tx_frame_if.sv
// uart_tx_frame_if: character handshake and per-frame configuration
interface uart_tx_frame_if #(parameter int DATA_MAX = 8);
  logic [DATA_MAX-1:0] tx_data;
  logic                tx_valid;
  logic                tx_ready;
  logic [1:0]          data_size;
  logic                parity_en;
  logic                parity_odd;
  logic                stop2;
  modport master (output tx_data, tx_valid, data_size, parity_en, parity_odd, stop2, input tx_ready);
  modport slave  (input tx_data, tx_valid, data_size, parity_en, parity_odd, stop2, output tx_ready);
endinterface

// File: rtl/uart_fall_det.sv
// uart_fall_det: sampled falling-edge detector, sample register resets high
module uart_fall_det (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic fall
);
  logic samp_d, samp_q;
  // sample the input every cycle
  always_comb samp_d = d;
  // previous-cycle sample; reset high so a low input right after reset reads as an edge
  always_ff @(posedge clk or negedge rst)
    if (!rst) samp_q <= 1'b1;
    else      samp_q <= samp_d;
  assign fall = samp_q & ~d;
endmodule

// File: rtl/uart_tx_frame.sv
// uart_tx_frame: serialise one character into a start/data/parity/stop frame
module uart_tx_frame
  import uart_pkg::*;
#(
  parameter int DATA_MAX = 8
) (
  input  logic             clk,
  input  logic             rst,
  uart_tx_frame_if.slave   bus,
  output logic             uart_en,
  input  logic             clk_uart,
  output logic             tx,
  output logic             busy
);
  uart_state_e         state_d, state_q;
  logic [DATA_MAX-1:0] data_d, data_q, mask;
  logic [2:0]          cnt_d, cnt_q;
  logic [1:0]          size_d, size_q;
  logic                par_en_d, par_en_q, stop2_d, stop2_q, par_d, par_q;
  logic                tx_d, tx_q, uart_en_d, uart_en_q, fall;

  uart_fall_det u_fall (.clk(clk), .rst(rst), .d(clk_uart), .fall(fall));

  // next-state, shift register, bit counter and line level
  always_comb begin
    state_d   = state_q;
    data_d    = data_q;
    cnt_d     = cnt_q;
    size_d    = size_q;
    par_en_d  = par_en_q;
    stop2_d   = stop2_q;
    par_d     = par_q;
    tx_d      = tx_q;
    uart_en_d = uart_en_q;
    mask      = ~({DATA_MAX{1'b1}} << size_bits(bus.data_size));
    unique case (state_q)
      IDLE: if (bus.tx_valid) begin
        data_d    = bus.tx_data & mask;
        size_d    = bus.data_size;
        par_en_d  = bus.parity_en;
        stop2_d   = bus.stop2;
        par_d     = (^(bus.tx_data & mask)) ^ bus.parity_odd;
        uart_en_d = 1'b1;
        state_d   = WAKE;
      end
      WAKE: if (fall) begin
        tx_d    = 1'b0;
        state_d = START;
      end
      START: if (fall) begin
        tx_d    = data_q[0];
        cnt_d   = 3'd0;
        state_d = DATA;
      end
      DATA: if (fall) begin
        if ({1'b0, cnt_q} == size_bits(size_q) - 4'd1) begin
          tx_d    = par_en_q ? par_q : TX_IDLE;
          state_d = par_en_q ? PARITY : STOP1;
        end else begin
          tx_d   = data_q[1];
          data_d = data_q >> 1;
          cnt_d  = cnt_q + 3'd1;
        end
      end
      PARITY: if (fall) begin
        tx_d    = TX_IDLE;
        state_d = STOP1;
      end
      STOP1: if (fall) begin
        uart_en_d = stop2_q;
        state_d   = stop2_q ? STOP2 : IDLE;
      end
      STOP2: if (fall) begin
        uart_en_d = 1'b0;
        state_d   = IDLE;
      end
      default: begin
        tx_d      = TX_IDLE;
        uart_en_d = 1'b0;
        state_d   = IDLE;
      end
    endcase
  end

  // state and datapath registers; reset abandons any frame in progress
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state_q   <= IDLE;
      data_q    <= '0;
      cnt_q     <= '0;
      size_q    <= DS_8;
      par_en_q  <= 1'b0;
      stop2_q   <= 1'b0;
      par_q     <= 1'b0;
      tx_q      <= TX_IDLE;
      uart_en_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      data_q    <= data_d;
      cnt_q     <= cnt_d;
      size_q    <= size_d;
      par_en_q  <= par_en_d;
      stop2_q   <= stop2_d;
      par_q     <= par_d;
      tx_q      <= tx_d;
      uart_en_q <= uart_en_d;
    end

  assign tx           = tx_q;
  assign uart_en      = uart_en_q;
  assign busy         = state_q != IDLE;
  assign bus.tx_ready = state_q == IDLE;
endmodule

// File: tb/tb_uart_tx_frame.sv
// tb_uart_tx_frame: directed frame vectors plus reset, back-to-back and stall sequences
module tb_uart_tx_frame;
  import uart_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic uart_en, clk_uart, tx, busy, stall;
  logic [3:0] gcnt;
  int n_pass = 0, n_total = 0;

  uart_tx_frame_if #(.DATA_MAX(8)) bus ();

  uart_tx_frame #(.DATA_MAX(8)) dut (
    .clk(clk), .rst(rst), .bus(bus), .uart_en(uart_en),
    .clk_uart(clk_uart), .tx(tx), .busy(busy)
  );

  always #5 clk = ~clk;

  // generator stub: forced low on enable, period 16 clk, frozen high while stalled
  always_ff @(posedge clk or negedge rst)
    if (!rst) gcnt <= '0;
    else      gcnt <= !uart_en ? 4'd0 : (stall ? gcnt : gcnt + 4'd1);
  assign clk_uart = !uart_en | stall | gcnt[3];

  typedef struct {
    logic [7:0]  data;
    logic [1:0]  size;
    logic        pen;
    logic        podd;
    logic        s2;
    logic [15:0] frame;
    int          nbits;
  } vec_t;
  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else n_pass++;
  endtask

  task automatic send(input logic [7:0] d, input logic [1:0] sz, input logic pe, input logic po,
                      input logic s2, input bit chk_start);
    bus.tx_data = d; bus.data_size = sz; bus.parity_en = pe; bus.parity_odd = po; bus.stop2 = s2;
    bus.tx_valid = 1'b1;
    @(negedge clk);
    check("accept_en", uart_en, 1'b1);
    check("accept_rdy", bus.tx_ready, 1'b0);
    bus.tx_valid = 1'b0;
    bus.tx_data = 8'h00; bus.data_size = 2'd0; bus.parity_en = 1'b0; bus.parity_odd = 1'b0; bus.stop2 = 1'b0;
    if (chk_start) begin
      @(negedge clk);
      check("start_lat", tx, 1'b0);
    end
  endtask

  // mid-bit samples of n bits from the start edge; len = cycles from start to busy low
  task automatic capture(input int n, output logic [15:0] bits, output int len);
    int t = 0, c = 0;
    bits = '0;
    len = -1;
    while (tx !== 1'b0 && t < 4000) begin @(negedge clk); t++; end
    if (t >= 4000) return;
    repeat (8) @(negedge clk);
    c = 8;
    bits[0] = tx;
    for (int i = 1; i < n; i++) begin
      repeat (16) @(negedge clk);
      c += 16;
      bits[i] = tx;
    end
    while (busy && c < 4000) begin @(negedge clk); c++; end
    len = c;
  endtask

  initial begin
    logic [15:0] bits;
    int len;
    vecs[0] = '{8'hA5, DS_8, 1'b0, 1'b0, 1'b0, 16'h034A, 10};
    vecs[1] = '{8'h07, DS_8, 1'b1, 1'b0, 1'b0, 16'h060E, 11};
    vecs[2] = '{8'h07, DS_8, 1'b1, 1'b1, 1'b0, 16'h040E, 11};
    vecs[3] = '{8'hFF, DS_5, 1'b1, 1'b0, 1'b0, 16'h00FE, 8};
    vecs[4] = '{8'h41, DS_7, 1'b0, 1'b0, 1'b1, 16'h0382, 10};
    vecs[5] = '{8'h5A, DS_6, 1'b1, 1'b1, 1'b1, 16'h0334, 10};
    stall = 1'b0;
    bus.tx_valid = 1'b0; bus.tx_data = 8'h00; bus.data_size = 2'd0;
    bus.parity_en = 1'b0; bus.parity_odd = 1'b0; bus.stop2 = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_tx", tx, 1'b1);
    check("rst_en", uart_en, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_rdy", bus.tx_ready, 1'b1);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    for (int v = 0; v < 6; v++) begin
      send(vecs[v].data, vecs[v].size, vecs[v].pen, vecs[v].podd, vecs[v].s2, 1'b1);
      capture(vecs[v].nbits, bits, len);
      check($sformatf("frame%0d", v), bits, vecs[v].frame);
      check($sformatf("len%0d", v), len, 16 * vecs[v].nbits);
      check($sformatf("end_en%0d", v), uart_en, 1'b0);
      check($sformatf("end_rdy%0d", v), bus.tx_ready, 1'b1);
      repeat (3) @(negedge clk);
    end

    bus.data_size = DS_8; bus.parity_en = 1'b0; bus.parity_odd = 1'b0; bus.stop2 = 1'b0;
    bus.tx_data = 8'h11; bus.tx_valid = 1'b1;
    @(negedge clk);
    check("b2b_acc0", bus.tx_ready, 1'b0);
    bus.tx_data = 8'h22;
    capture(10, bits, len);
    check("b2b_frame0", bits, 16'h0222);
    check("b2b_gap0", uart_en, 1'b0);
    @(negedge clk);
    check("b2b_acc1", bus.tx_ready, 1'b0);
    bus.tx_data = 8'h33;
    capture(10, bits, len);
    check("b2b_frame1", bits, 16'h0244);
    check("b2b_gap1", uart_en, 1'b0);
    @(negedge clk);
    check("b2b_acc2", bus.tx_ready, 1'b0);
    bus.tx_valid = 1'b0;
    capture(10, bits, len);
    check("b2b_frame2", bits, 16'h0266);
    repeat (40) @(negedge clk);
    check("b2b_no_dup", busy, 1'b0);

    send(8'hA5, DS_8, 1'b0, 1'b0, 1'b0, 1'b1);
    repeat (72) @(negedge clk);
    rst = 1'b0;
    #1;
    check("mid_rst_tx", tx, 1'b1);
    check("mid_rst_en", uart_en, 1'b0);
    check("mid_rst_rdy", bus.tx_ready, 1'b1);
    check("mid_rst_busy", busy, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    send(8'h3C, DS_8, 1'b0, 1'b0, 1'b0, 1'b1);
    capture(10, bits, len);
    check("post_rst_frame", bits, 16'h0278);
    check("post_rst_len", len, 160);
    repeat (3) @(negedge clk);

    stall = 1'b1;
    send(8'h07, DS_8, 1'b1, 1'b0, 1'b0, 1'b0);
    repeat (40) @(negedge clk);
    check("stall_tx", tx, 1'b1);
    check("stall_busy", busy, 1'b1);
    check("stall_en", uart_en, 1'b1);
    stall = 1'b0;
    capture(11, bits, len);
    check("stall_frame", bits, 16'h060E);
    check("stall_len", len, 176);
    check("stall_end_rdy", bus.tx_ready, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
